// File: rtl/jtopl_timer_regs.sv
// CPU port decoder for the OPL timer pair: register select, timer controls, status reads, write-busy window.
// Latency: outputs update 1 clk after the write edge; no backpressure, busy is advisory only.
module jtopl_timer_regs #(
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84,
  parameter int CW        = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       reg_wr,
  output logic [7:0] reg_sel,
  output logic [7:0] reg_dout,
  output logic [7:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       flagen_A,
  output logic       flagen_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       irq_n
);

  logic          wr_act;
  logic          wr_act_l;
  logic          wr_edge;
  logic          rd_act;
  logic [CW-1:0] busy_cnt;

  assign wr_act  = ~cs_n & ~wr_n;
  assign wr_edge = wr_act & ~wr_act_l;
  assign rd_act  = ~cs_n & ~rd_n & wr_n;
  assign busy    = (busy_cnt != '0);

  // Resetting to 1 means a write still held across reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_act_l <= 1'b1;
    else        wr_act_l <= wr_act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (wr_edge) begin
      busy_cnt <= addr ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
    end else if (cen && busy) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_sel    <= 8'h00;
      reg_dout   <= 8'h00;
      reg_wr     <= 1'b0;
      value_A    <= 8'h00;
      value_B    <= 8'h00;
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      flagen_A   <= 1'b1;
      flagen_B   <= 1'b1;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
    end else begin
      reg_wr     <= 1'b0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      if (wr_edge) begin
        if (!addr) begin
          reg_sel <= din;
        end else begin
          reg_dout <= din;
          reg_wr   <= 1'b1;
          case (reg_sel)
            8'h02: value_A <= din;
            8'h03: value_B <= din;
            8'h04: begin
              // Bit 7 is a pure flag-reset command; it leaves loads and masks alone.
              if (din[7]) begin
                clr_flag_A <= 1'b1;
                clr_flag_B <= 1'b1;
              end else begin
                load_A   <= din[0];
                load_B   <= din[1];
                flagen_A <= ~din[6];
                flagen_B <= ~din[5];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dout <= 8'h00;
    else if (rd_act) dout <= addr ? 8'h00 : {~irq_n, flag_A, flag_B, 5'b0};
  end

endmodule

// File: doc/jtopl_timer_regs.md
# jtopl_timer_regs

CPU-side register writer for the OPL timer pair. Decodes CPU address/data port writes into the timer controls (start values, load, flag mask, flag clear), returns the status byte on reads, and generates the chip's write-busy window. Sits between the CPU bus and the timer block. Also forwards every data-port write to the rest of the chip as a one-cycle strobe.

## Interface
- ADDR_WAIT, 12: cen ticks of busy after an address-port write
- DATA_WAIT, 84: cen ticks of busy after a data-port write
- CW, 7: busy counter width; must hold max(ADDR_WAIT, DATA_WAIT)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable at chip input-clock rate; busy counter only
- cs_n  in  1  chip select, active low
- wr_n  in  1  write strobe, active low
- rd_n  in  1  read strobe, active low
- addr  in  1  0 = address/status port, 1 = data port
- din  in  8  CPU write data
- dout  out  8  status byte
- busy  out  1  write-busy window active
- reg_wr  out  1  one-clk pulse per data-port write
- reg_sel  out  8  currently selected register number
- reg_dout  out  8  data of last data-port write
- value_A, value_B  out  8  timer start values (regs 0x02, 0x03)
- load_A, load_B  out  1  timer run levels (reg 0x04 bits 0, 1)
- flagen_A, flagen_B  out  1  flag enables = inverted masks (reg 0x04 bits 6, 5)
- clr_flag_A, clr_flag_B  out  1  one-clk flag clear pulses
- flag_A, flag_B  in  1  gated timer flags
- irq_n  in  1  timer interrupt, active low

## Operation
- All bus inputs are synchronous to clk. wr_act = !cs_n & !wr_n; a write is accepted on the cycle wr_act rises (registered previous value). A write held low for many cycles is one write.
- Address-port write (addr=0): reg_sel <= din; busy counter <= ADDR_WAIT.
- Data-port write (addr=1): reg_dout <= din; reg_wr pulses; busy counter <= DATA_WAIT. Decode on current reg_sel:
  - 0x02: value_A <= din. 0x03: value_B <= din.
  - 0x04 with din[7]=1: clr_flag_A and clr_flag_B pulse together; loads and masks unchanged.
  - 0x04 with din[7]=0: load_A <= din[0], load_B <= din[1], flagen_A <= ~din[6], flagen_B <= ~din[5].
  - any other number: only reg_wr/reg_dout/busy effects.
- Writes while busy=1 are accepted normally and restart the counter with the new wait; busy is advisory.
- Busy counter: decrements by 1 on each cen while non-zero; busy = (counter != 0). No wrap below zero.
- Read: when !cs_n & !rd_n & wr_n, dout <= addr ? 8'h00 : {~irq_n, flag_A, flag_B, 5'b0}, updated every clk while read active; holds last value otherwise. Write and read asserted together: write wins, dout holds.
- Reset values: reg_sel 0, reg_dout 0, value_A/B 0, load_A/B 0, flagen_A/B 1, clr_flag_A/B 0, reg_wr 0, busy counter 0 (busy 0), dout 0. Reset mid-busy aborts the window immediately. Reset mid-write: no write edge is recognised until wr_act is seen low after release.

## Timing
- Write edge sampled at cycle N: reg_sel/value/load/flagen/reg_dout updated and reg_wr, clr_flag pulses high at N+1; pulses low at N+2.
- busy high from N+1; with cen=1 every clk, busy drops at N+1+WAIT (exactly WAIT cycles high). With sparser cen, busy spans exactly WAIT cen ticks after N.
- load_A rising at N+1 lets the timer reload on its own edge detector; consecutive 0x04 writes with load bit 1 produce no new edge.
- dout reflects flags/irq sampled one clk earlier (registered).

## Test plan
- Reset, then idle: all outputs at reset values, flagen_A=flagen_B=1, busy=0, dout=0x00.
- Write addr 0x02, data 0xA5: reg_sel=0x02 one clk after first write; value_A=0xA5 and reg_wr high for exactly one clk after second; busy high 84 clk (cen=1).
- Reg 0x04 data 0x43: load_A=1, load_B=1, flagen_A=0, flagen_B=1; then data 0x80: clr_flag_A/B pulse once, load/flagen unchanged.
- Drive flag_A=1, flag_B=0, irq_n=0, read addr 0: dout=0xC0; read addr 1: dout=0x00; simultaneous rd/wr: write applied, dout unchanged.
- cen every 4th clk, address write: busy spans 12 cen ticks (48 clk); second data write at tick 5 restarts to 84 ticks.
- Assert rst_n low mid-busy and mid-held write: busy drops asynchronously; after release, still-low wr_n produces no write until it returns high then low.
